// File: rtl/sec_counter_6bit.sv
// Stopwatch seconds core: debounced start/stop and clear buttons, run/pause/idle
// control, and a prescaled 0..MAX_COUNT counter with registered tick/wrap pulses.
module sec_counter_6bit #(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_COUNT       = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [5:0] count,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]    COUNT_MAX  = 6'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // Bit 0 = start/stop, bit 1 = clear.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1, sync2, deb, deb_q, press;
  logic [DW-1:0] db_cnt [2];

  state_t        state, state_next;
  logic          running_next;
  logic [PW-1:0] presc;
  logic          ss_ev, clr_ev;
  logic          advance, terminal, at_max;

  assign btn_raw = {btn_clear, btn_start_stop};
  assign ss_ev   = press[0];
  assign clr_ev  = press[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= ~deb[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= running_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clr_ev) begin
      state_next = IDLE;
    end else if (ss_ev) begin
      unique case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    running_next = (state_next == RUN);
  end

  // The cycle carrying a pause or clear event does not count as a RUN cycle,
  // so a terminal prescaler in that cycle is held (pause) or discarded (clear).
  always_comb begin
    advance  = (state == RUN) && !ss_ev && !clr_ev;
    terminal = advance && (presc == PRESC_LAST);
    at_max   = (count == COUNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= terminal;
      wrap <= terminal && at_max;
      if (clr_ev) begin
        presc <= '0;
        count <= '0;
      end else if ((state == IDLE) && ss_ev) begin
        presc <= '0;
      end else if (terminal) begin
        presc <= '0;
        count <= at_max ? '0 : count + 6'd1;
      end else if (advance) begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sec_counter_6bit.sv
// Scoreboard bench for sec_counter_6bit: expected tick values are queued as
// stimulus is applied and popped whenever the counter emits a tick.
module tb_sec_counter_6bit;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int unsigned MAXC     = 59;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start_stop;
  logic       btn_clear;
  logic [5:0] count;
  logic       running;
  logic       tick;
  logic       wrap;

  typedef struct {
    logic [5:0] cnt;
    logic       wr;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   n_ticks = 0;
  int   last_tick_cyc = -1;
  int   last_rise_cyc = -1;
  int   last_fall_cyc = -1;
  logic run_prev = 1'b0;

  sec_counter_6bit #(
    .TICK_DIV        (TICK_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .MAX_COUNT       (MAXC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .count          (count),
    .running        (running),
    .tick           (tick),
    .wrap           (wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      run_prev = 1'b0;
    end else begin
      if (tick) begin
        n_ticks++;
        last_tick_cyc = cyc;
        if (sb_q.size() == 0) begin
          check("tick_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("tick_count", int'(count), int'(e.cnt));
          check("tick_wrap", int'(wrap), int'(e.wr));
        end
      end else if (wrap) begin
        check("wrap_without_tick", 1, 0);
      end
      if (running && !run_prev) last_rise_cyc = cyc;
      if (!running && run_prev) last_fall_cyc = cyc;
      run_prev = running;
    end
  end

  task automatic push_cnt(input int v, input bit w);
    exp_t e;
    e.cnt = 6'(v);
    e.wr  = w;
    sb_q.push_back(e);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) push_cnt(v, 1'b0);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step(1);
    if (cyc != target) check("wait_cyc_overshoot", cyc, target);
  endtask

  task automatic wait_ticks(input int target, input int budget);
    int b;
    b = 0;
    while (n_ticks < target && b < budget) begin
      step(1);
      b++;
    end
    if (n_ticks < target) check("tick_timeout", n_ticks, target);
  endtask

  task automatic hold_btns(input bit ss, input bit clr, input int hold);
    btn_start_stop = ss;
    btn_clear      = clr;
    step(hold);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
  endtask

  initial begin
    int k, r, s, tgt;
    rst_n          = 1'b0;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    step(3);
    check("reset_count", int'(count), 0);
    check("reset_running", int'(running), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_wrap", int'(wrap), 0);
    rst_n = 1'b1;
    step(3);

    // Continuous run through a wrap, then on to 17 for the mid-count reset.
    push_range(1, 59);
    push_cnt(0, 1'b1);
    push_range(1, 17);
    k = cyc + 1;
    hold_btns(1'b1, 1'b0, 10);
    check("start_latency", last_rise_cyc - k, 6);
    r = last_rise_cyc;
    wait_ticks(60, 300);
    check("ticks60_cycles", last_tick_cyc - r, 240);
    wait_ticks(77, 100);
    check("count_before_reset", int'(count), 17);
    step(1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_count", int'(count), 0);
    check("async_reset_running", int'(running), 0);
    check("async_reset_tick", int'(tick), 0);
    check("async_reset_wrap", int'(wrap), 0);
    check("sb_empty_at_reset", sb_q.size(), 0);
    step(2);
    rst_n = 1'b1;
    step(5);
    check("idle_after_reset_running", int'(running), 0);
    check("idle_after_reset_count", int'(count), 0);

    // Bounces shorter than the debounce window produce no event.
    btn_start_stop = 1'b1; step(2);
    btn_start_stop = 1'b0; step(1);
    btn_start_stop = 1'b1; step(2);
    btn_start_stop = 1'b0; step(15);
    check("bounce_no_event", int'(running), 0);
    check("bounce_count", int'(count), 0);

    // Long hold starts the run; pause at count 5 with prescaler at 2.
    push_range(1, 5);
    k = cyc + 1;
    hold_btns(1'b1, 1'b0, 10);
    check("hold_latency", last_rise_cyc - k, 6);
    r = last_rise_cyc;
    wait_cyc(r + 16);
    check("hold_single_event", int'(running), 1);
    check("count_at_r16", int'(count), 4);
    hold_btns(1'b1, 1'b0, 8);
    check("pause_edge", last_fall_cyc - r, 23);
    check("pause_running", int'(running), 0);
    check("pause_count", int'(count), 5);
    step(25);
    check("pause_hold_count_a", int'(count), 5);
    step(25);
    check("pause_hold_count_b", int'(count), 5);
    check("pause_hold_running", int'(running), 0);
    push_cnt(6, 1'b0);
    tgt = n_ticks + 1;
    hold_btns(1'b1, 1'b0, 8);
    s = last_rise_cyc;
    wait_ticks(tgt, 10);
    check("resume_tick_delay", last_tick_cyc - s, 2);

    // Plain clear from RUN.
    push_cnt(7, 1'b0);
    hold_btns(1'b0, 1'b1, 8);
    check("clear_count", int'(count), 0);
    check("clear_running", int'(running), 0);
    check("clear_sb_drained", sb_q.size(), 0);
    step(6);

    // Coincident clear and start/stop at count 33: clear wins.
    push_range(1, 33);
    hold_btns(1'b1, 1'b0, 10);
    r = last_rise_cyc;
    wait_cyc(r + 127);
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    wait_cyc(r + 133);
    check("prio_pre_count", int'(count), 33);
    check("prio_pre_running", int'(running), 1);
    step(1);
    check("prio_count", int'(count), 0);
    check("prio_running", int'(running), 0);
    check("prio_tick", int'(tick), 0);
    wait_cyc(r + 135);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    step(10);
    check("prio_stays_idle", int'(running), 0);
    check("prio_stays_zero", int'(count), 0);

    // Clear aligned with the terminal prescaler at count 59.
    push_range(1, 59);
    hold_btns(1'b1, 1'b0, 10);
    r = last_rise_cyc;
    wait_cyc(r + 233);
    btn_clear = 1'b1;
    wait_cyc(r + 239);
    check("term_pre_count", int'(count), 59);
    check("term_pre_running", int'(running), 1);
    step(1);
    check("term_count", int'(count), 0);
    check("term_tick", int'(tick), 0);
    check("term_wrap", int'(wrap), 0);
    check("term_running", int'(running), 0);
    wait_cyc(r + 241);
    btn_clear = 1'b0;
    step(12);
    check("term_stays_idle", int'(running), 0);
    check("term_stays_zero", int'(count), 0);
    check("final_sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
